// File: rtl/cook_timer_ctrl.sv
// cook_timer_ctrl
//   Kitchen countdown timer controller. The user sets MM:SS while idle,
//   starts and pauses the countdown, and hears an alarm for ALARM_SEC
//   seconds once the countdown reaches zero.
//
// Ports
//   clk          system clock, rising edge active
//   reset_p      asynchronous active-high reset
//   clk_sec      one-clk strobe, once per second
//   btn_start    start/pause toggle pulse (also silences the alarm)
//   btn_clear    abort pulse, zeroes the time
//   btn_inc_sec  seconds +1 while idle
//   btn_inc_min  minutes +1 while idle
//   sec1..min10  registered BCD remaining time MM:SS
//   state        registered state: IDLE=00 RUN=01 PAUSE=10 ALARM=11
//   running      registered, high in RUN
//   alarm        registered, high in ALARM
module cook_timer_ctrl #(
  parameter int ALARM_SEC = 5
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       clk_sec,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_inc_sec,
  input  logic       btn_inc_min,
  output logic [3:0] sec1,
  output logic [3:0] sec10,
  output logic [3:0] min1,
  output logic [3:0] min10,
  output logic [1:0] state,
  output logic       running,
  output logic       alarm
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    ALARM = 2'b11
  } state_t;

  // Counter value seen on the strobe that ends the alarm.
  localparam logic [3:0] ALARM_LAST = 4'(ALARM_SEC - 1);

  state_t     state_q, state_d;
  logic [3:0] sec1_q, sec1_d;
  logic [3:0] sec10_q, sec10_d;
  logic [3:0] min1_q, min1_d;
  logic [3:0] min10_q, min10_d;
  logic [3:0] cnt_q, cnt_d;
  logic       running_q, running_d;
  logic       alarm_q, alarm_d;

  logic time_zero;
  logic time_one;

  // Increment a two-digit BCD field 00..59, wrapping 59 -> 00.
  function automatic logic [7:0] bcd_inc59(input logic [3:0] tens,
                                           input logic [3:0] ones);
    logic [3:0] t;
    logic [3:0] o;
    t = tens;
    o = ones;
    if (o == 4'd9) begin
      o = 4'd0;
      t = (t == 4'd5) ? 4'd0 : t + 4'd1;
    end else begin
      o = o + 4'd1;
    end
    return {t, o};
  endfunction

  assign time_zero = (min10_q == 4'd0) && (min1_q == 4'd0) &&
                     (sec10_q == 4'd0) && (sec1_q == 4'd0);
  assign time_one  = (min10_q == 4'd0) && (min1_q == 4'd0) &&
                     (sec10_q == 4'd0) && (sec1_q == 4'd1);

  always_comb begin
    state_d = state_q;
    sec1_d  = sec1_q;
    sec10_d = sec10_q;
    min1_d  = min1_q;
    min10_d = min10_q;
    cnt_d   = cnt_q;

    if (btn_clear) begin
      state_d = IDLE;
      sec1_d  = 4'd0;
      sec10_d = 4'd0;
      min1_d  = 4'd0;
      min10_d = 4'd0;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          // A start pulse owns the cycle even when it is refused at 00:00.
          if (btn_start) begin
            if (!time_zero) state_d = RUN;
          end else begin
            if (btn_inc_sec) {sec10_d, sec1_d} = bcd_inc59(sec10_q, sec1_q);
            if (btn_inc_min) {min10_d, min1_d} = bcd_inc59(min10_q, min1_q);
          end
        end
        RUN: begin
          if (btn_start) begin
            state_d = PAUSE;
          end else if (clk_sec) begin
            // RUN is only ever held with a nonzero time, so min10 cannot underflow.
            if (sec1_q != 4'd0) begin
              sec1_d = sec1_q - 4'd1;
            end else begin
              sec1_d = 4'd9;
              if (sec10_q != 4'd0) begin
                sec10_d = sec10_q - 4'd1;
              end else begin
                sec10_d = 4'd5;
                if (min1_q != 4'd0) begin
                  min1_d = min1_q - 4'd1;
                end else begin
                  min1_d  = 4'd9;
                  min10_d = min10_q - 4'd1;
                end
              end
            end
            if (time_one) begin
              state_d = ALARM;
              cnt_d   = 4'd0;
            end
          end
        end
        PAUSE: begin
          if (btn_start) state_d = RUN;
        end
        ALARM: begin
          if (btn_start) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else if (clk_sec) begin
            if (cnt_q == ALARM_LAST) begin
              state_d = IDLE;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    running_d = (state_d == RUN);
    alarm_d   = (state_d == ALARM);
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q   <= IDLE;
      sec1_q    <= 4'd0;
      sec10_q   <= 4'd0;
      min1_q    <= 4'd0;
      min10_q   <= 4'd0;
      cnt_q     <= 4'd0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sec1_q    <= sec1_d;
      sec10_q   <= sec10_d;
      min1_q    <= min1_d;
      min10_q   <= min10_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      alarm_q   <= alarm_d;
    end
  end

  assign sec1    = sec1_q;
  assign sec10   = sec10_q;
  assign min1    = min1_q;
  assign min10   = min10_q;
  assign state   = state_q;
  assign running = running_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
module tb_cook_timer_ctrl;

  localparam int ALARM_SEC = 5;

  logic       clk;
  logic       reset_p;
  logic       clk_sec;
  logic       btn_start;
  logic       btn_clear;
  logic       btn_inc_sec;
  logic       btn_inc_min;
  logic [3:0] sec1, sec10, min1, min10;
  logic [1:0] state;
  logic       running;
  logic       alarm;

  cook_timer_ctrl #(.ALARM_SEC(ALARM_SEC)) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .clk_sec    (clk_sec),
    .btn_start  (btn_start),
    .btn_clear  (btn_clear),
    .btn_inc_sec(btn_inc_sec),
    .btn_inc_min(btn_inc_min),
    .sec1       (sec1),
    .sec10      (sec10),
    .min1       (min1),
    .min10      (min10),
    .state      (state),
    .running    (running),
    .alarm      (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] vec;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;
  string phase = "init";

  // Reference model: time held as plain minute and second integers,
  // state as the externally visible code (0 idle, 1 run, 2 pause, 3 alarm).
  int m_st = 0;
  int m_mm = 0;
  int m_ss = 0;
  int m_cnt = 0;

  function automatic logic [19:0] model_vec();
    logic [1:0] st;
    logic [3:0] m10, m1, s10, s1;
    st  = 2'(m_st);
    m10 = 4'(m_mm / 10);
    m1  = 4'(m_mm % 10);
    s10 = 4'(m_ss / 10);
    s1  = 4'(m_ss % 10);
    return {st, (m_st == 1), (m_st == 3), m10, m1, s10, s1};
  endfunction

  function automatic logic [19:0] dut_vec();
    return {state, running, alarm, min10, min1, sec10, sec1};
  endfunction

  task automatic compare(input logic [19:0] exp, input string tag);
    logic [19:0] act;
    act = dut_vec();
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got st=%b run=%b alm=%b %h%h:%h%h, expected st=%b run=%b alm=%b %h%h:%h%h",
               tag, act[19:18], act[17], act[16], act[15:12], act[11:8], act[7:4], act[3:0],
               exp[19:18], exp[17], exp[16], exp[15:12], exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic model_step(input bit st, input bit clr, input bit isec,
                            input bit imin, input bit sec);
    int t;
    if (clr) begin
      m_st = 0; m_mm = 0; m_ss = 0; m_cnt = 0;
    end else begin
      case (m_st)
        0: begin
          if (st) begin
            if (m_mm != 0 || m_ss != 0) m_st = 1;
          end else begin
            if (isec) m_ss = (m_ss + 1) % 60;
            if (imin) m_mm = (m_mm + 1) % 60;
          end
        end
        1: begin
          if (st) m_st = 2;
          else if (sec) begin
            t = m_mm * 60 + m_ss - 1;
            m_mm = t / 60;
            m_ss = t % 60;
            if (t == 0) begin
              m_st = 3;
              m_cnt = 0;
            end
          end
        end
        2: if (st) m_st = 1;
        default: begin
          if (st) begin
            m_st = 0; m_cnt = 0;
          end else if (sec) begin
            m_cnt++;
            if (m_cnt == ALARM_SEC) begin
              m_st = 0; m_cnt = 0;
            end
          end
        end
      endcase
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue the response
  // expected after the next rising edge.
  task automatic step(input bit st, input bit clr, input bit isec,
                      input bit imin, input bit sec);
    exp_t e;
    @(negedge clk);
    btn_start   = st;
    btn_clear   = clr;
    btn_inc_sec = isec;
    btn_inc_min = imin;
    clk_sec     = sec;
    model_step(st, clr, isec, imin, sec);
    e.vec = model_vec();
    e.tag = phase;
    q.push_back(e);
  endtask

  task automatic idle_inputs();
    btn_start = 0; btn_clear = 0; btn_inc_sec = 0; btn_inc_min = 0; clk_sec = 0;
  endtask

  // Reset is asserted between clock edges; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    @(negedge clk);
    idle_inputs();
    #2;
    reset_p = 1'b1;
    #1;
    m_st = 0; m_mm = 0; m_ss = 0; m_cnt = 0;
    compare(model_vec(), tag);
    @(negedge clk);
    reset_p = 1'b0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      compare(e.vec, e.tag);
    end
  end

  initial begin
    int r;
    bit b_st, b_clr, b_is, b_im, b_sec;
    idle_inputs();
    reset_p = 1'b1;
    #1;
    compare(model_vec(), "reset_state");
    @(negedge clk);
    reset_p = 1'b0;

    phase = "inc_sec_60";
    for (int i = 0; i < 60; i++) step(0, 0, 1, 0, 0);

    phase = "run_01_00";
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++) step(0, 0, 0, 0, 1);
    phase = "alarm_expire";
    for (int i = 0; i < ALARM_SEC; i++) begin
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
    end

    phase = "pause_10_00";
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);

    phase = "clear_05_30";
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
    for (int i = 0; i < 30; i++) step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1);

    phase = "start_at_zero";
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);

    phase = "reset_03_07";
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    do_reset("async_reset_run");
    phase = "after_reset";
    step(0, 0, 1, 0, 1);

    phase = "alarm_silence";
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    phase = "random";
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(99); b_sec = (r < 35);
      r = $urandom_range(99); b_st  = (r < 5);
      r = $urandom_range(199); b_clr = (r < 1);
      r = $urandom_range(99); b_is  = (r < 12);
      r = $urandom_range(99); b_im  = (r < 3);
      step(b_st, b_clr, b_is, b_im, b_sec);
    end

    phase = "random_tail";
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    do_reset("async_reset_tail");
    step(0, 0, 0, 0, 0);

    @(negedge clk);
    idle_inputs();
    repeat (4) @(negedge clk);
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expected entries left, 0 required", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cook_timer_ctrl.md
COOK_TIMER_CTRL -- requirements
Module: cook_timer_ctrl

Interface
REQ-001 Parameter ALARM_SEC, default 5, alarm duration in clk_sec strobes (1..15).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset_p  input  1  asynchronous, active-high reset.
REQ-004 clk_sec  input  1  one-clk-wide strobe, once per second.
REQ-005 btn_start  input  1  one-clk-wide pulse, edge-detected upstream; start/pause toggle.
REQ-006 btn_clear  input  1  one-clk-wide pulse; abort and zero the time.
REQ-007 btn_inc_sec  input  1  one-clk-wide pulse; seconds +1 while setting.
REQ-008 btn_inc_min  input  1  one-clk-wide pulse; minutes +1 while setting.
REQ-009 sec1, sec10, min1, min10  output  4 each  registered BCD remaining time MM:SS.
REQ-010 state  output  2  registered FSM state: IDLE=00, RUN=01, PAUSE=10, ALARM=11.
REQ-011 running  output  1  registered; 1 exactly when state==RUN.
REQ-012 alarm  output  1  registered; 1 exactly when state==ALARM.

Function
REQ-013 All outputs SHALL be registered and update on the clk edge that samples the causing input; latency 1 clk, no combinational input-to-output path.
REQ-014 Input priority within one cycle SHALL be btn_clear > btn_start > clk_sec > btn_inc_min/btn_inc_sec.
REQ-015 IDLE: btn_inc_sec increments SS BCD 00..59, wrapping 59->00 without carry into MM.
REQ-016 IDLE: btn_inc_min increments MM BCD 00..59, wrapping 59->00.
REQ-017 IDLE: btn_inc_sec and btn_inc_min in the same cycle both apply.
REQ-018 IDLE: btn_start with time != 00:00 -> RUN; with time == 00:00 it is ignored and the state stays IDLE.
REQ-019 IDLE: clk_sec is ignored.
REQ-020 RUN: each clk_sec decrements MM:SS by one second with BCD borrow:
- sec1 0->9 with borrow into sec10
- sec10 0->5 with borrow into min1
- min1 0->9 with borrow into min10
- min10 decrements
REQ-021 RUN: the clk_sec that decrements 00:01 to 00:00 SHALL move the state to ALARM on the same edge.
REQ-022 RUN: btn_start -> PAUSE; a coincident clk_sec is discarded, with no decrement.
REQ-023 PAUSE: the time holds and clk_sec is ignored; btn_start -> RUN.
REQ-024 RUN, PAUSE and ALARM: btn_inc_sec and btn_inc_min are ignored.
REQ-025 Any state: btn_clear -> IDLE with MM:SS = 00:00 and the alarm counter cleared, regardless of other inputs.
REQ-026 ALARM: the time stays 00:00; an internal 4-bit counter, zeroed on ALARM entry, counts clk_sec strobes.
REQ-027 ALARM: on the ALARM_SEC-th clk_sec the state SHALL return to IDLE.
REQ-028 ALARM: btn_start or btn_clear -> IDLE immediately.
REQ-029 BCD digits SHALL never hold values outside 0..9 (sec10 and min10 outside 0..5).
REQ-030 The state register SHALL have no unreachable encodings; all four codes are used.

Reset
REQ-031 On reset_p high, asynchronously: state=IDLE, MM:SS=00:00, running=0, alarm=0, alarm counter=0.
REQ-032 reset_p asserted mid-RUN or mid-ALARM SHALL abort immediately, with no pending decrement or transition applied after release.
REQ-033 After reset_p deasserts, the first active edge SHALL behave as IDLE.

Verification
REQ-034 IDLE, 60 btn_inc_sec pulses -> SS 01..59 then 00; MM stays 00.
REQ-035 Set 01:00, btn_start, 1 clk_sec -> running=1, time 00:59 on the strobe edge; 59 more strobes -> 00:00 with state=ALARM and alarm=1 on the 60th strobe edge.
REQ-036 ALARM with ALARM_SEC=5, 5 clk_sec strobes -> state=IDLE and alarm=0 on the 5th strobe edge; time stays 00:00.
REQ-037 RUN at 10:00, btn_start and clk_sec in the same cycle -> state=PAUSE, time stays 10:00; further strobes leave it unchanged; btn_start -> RUN; next strobe gives 09:59.
REQ-038 RUN at 05:30, btn_clear, btn_start and clk_sec in the same cycle -> IDLE, 00:00, running=0.
REQ-039 IDLE at 00:00, btn_start -> state stays IDLE; reset_p pulse mid-RUN at 03:07 -> IDLE, 00:00 asynchronously, without waiting for a clk edge.
